// File: rtl/bios_loader_pkg.sv
// bios_loader_pkg: shared constants and pad sequencer states for the BIOS stream loader.
package bios_loader_pkg;
    localparam int BURST_LOG2 = 5;
    localparam int BURST_WORDS = 1 << BURST_LOG2;
    localparam int BUF_WORDS = 2 * BURST_WORDS;
    localparam logic [15:0] PAD_WORD = 16'hFFFF;
    localparam int MAX_BYTES = 16384;
    typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} pad_state_e;
endpackage

// File: rtl/bios_stream_loader_if.sv
// bios_stream_loader_if: data_io byte stream in, system BIOS word port out.
interface bios_stream_loader_if #(parameter int ADDR_W = 13) ();
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              bios_req;
    logic              bios_wr;
    logic [ADDR_W-1:0] bios_addr;
    logic [15:0]       bios_din;
    logic              bios_loaded;
    logic              overrun;
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        output bios_wr, bios_addr, bios_din, bios_loaded, overrun
    );
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        input  bios_wr, bios_addr, bios_din, bios_loaded, overrun
    );
endinterface

// File: rtl/bios_word_buf.sv
// bios_word_buf: simple dual-port word RAM, one write port and one registered read port.
module bios_word_buf #(parameter int AW = bios_loader_pkg::BURST_LOG2 + 1) (
    input  logic          clk_sdr,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [15:0]   wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [15:0]   rd
);
    logic [15:0] mem [2**AW];
    logic [15:0] rd_q, rd_d;
    always_ff @(posedge clk_sdr) begin
        if (we) mem[wa] <= wd;
    end
    always_comb rd_d = re ? mem[ra] : rd_q;
    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n) rd_q <= '0;
        else rd_q <= rd_d;
    end
    assign rd = rd_q;
endmodule

// File: rtl/bios_stream_loader.sv
// bios_stream_loader: pairs data_io bytes into words in a ping-pong buffer and
// hands them to the system BIOS port one 32-word burst at a time.
module bios_stream_loader #(
    parameter int          ADDR_W     = 13,
    parameter int          BURST_LOG2 = bios_loader_pkg::BURST_LOG2,
    parameter logic [15:0] PAD_WORD   = bios_loader_pkg::PAD_WORD
) (
    input logic                clk_sdr,
    input logic                reset_n,
    bios_stream_loader_if.slave bus
);
    import bios_loader_pkg::pad_state_e;
    import bios_loader_pkg::IDLE;
    import bios_loader_pkg::LOAD;
    import bios_loader_pkg::PAD;
    import bios_loader_pkg::DONE;
    import bios_loader_pkg::MAX_BYTES;

    localparam int IW = BURST_LOG2 + 1;
    localparam int LIM = $clog2(MAX_BYTES);

    pad_state_e state_q, state_d;
    logic dl_q, dl_d, req_q, req_d, wr_q, wr_d, loaded_q, loaded_d;
    logic overrun_q, overrun_d, partial_q, partial_d, low_vld_q, low_vld_d, got_q, got_d;
    logic [7:0] low_q, low_d;
    logic [1:0] pend_q, pend_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic start, stop, req_fall, dec, inc, io_wr, odd, half_end, bad, accept, rd_en;
    logic pad_we, pad_last, buf_we, unused_addr;
    logic [IW-1:0] buf_wa;
    logic [15:0] buf_wd, rd_word;

    assign start = bus.ioctl_download & ~dl_q;
    assign stop = ~bus.ioctl_download & dl_q;
    assign req_fall = ~bus.bios_req & req_q;
    assign dec = req_fall & got_q;
    assign io_wr = bus.ioctl_download & bus.ioctl_wr & ~start;
    assign odd = bus.ioctl_addr[0];
    assign half_end = odd & (&bus.ioctl_addr[BURST_LOG2:1]);
    assign bad = |bus.ioctl_addr[24:LIM];
    // With both halves pending the writer would land on undrained data, so drop it.
    assign accept = io_wr & ~bad & ((pend_q != 2'd2) | dec);
    assign rd_en = bus.bios_req & wr_q;
    assign inc = (accept & half_end) | pad_last;
    assign unused_addr = ^bus.ioctl_addr[LIM-1:IW+1];

    always_comb begin
        state_d = state_q;
        if (start) state_d = LOAD;
        else if (state_q == LOAD && stop) state_d = (partial_q || low_vld_q) ? PAD : DONE;
        else if (pad_last) state_d = DONE;
    end

    always_comb begin
        pad_we = state_q == PAD;
        pad_last = pad_we && (&ptr_q[BURST_LOG2-1:0]);
    end

    always_comb begin
        dl_d = bus.ioctl_download;
        req_d = bus.bios_req;
        low_d = low_q;
        low_vld_d = low_vld_q;
        partial_d = partial_q;
        ptr_d = ptr_q;
        overrun_d = overrun_q | (io_wr & bad) | (io_wr & ~bad & half_end & (pend_q == 2'd2) & ~dec);
        got_d = req_fall ? 1'b0 : (got_q | rd_en);
        addr_d = addr_q + ADDR_W'(rd_en);
        pend_d = pend_q + 2'(inc) - 2'(dec);
        if (accept && !odd) begin
            low_d = bus.ioctl_dout;
            low_vld_d = 1'b1;
        end
        if (accept && odd) begin
            low_vld_d = 1'b0;
            partial_d = ~half_end;
            ptr_d = bus.ioctl_addr[IW:1] + IW'(1);
        end
        if (pad_we) begin
            low_vld_d = 1'b0;
            ptr_d = ptr_q + IW'(1);
        end
        if (pad_last) partial_d = 1'b0;
        wr_d = (pend_d != 2'd0) && !req_fall;
        loaded_d = loaded_q | (state_q == DONE && pend_d == 2'd0);
        if (start) begin
            addr_d = '0;
            pend_d = '0;
            wr_d = 1'b0;
            loaded_d = 1'b0;
            overrun_d = 1'b0;
            partial_d = 1'b0;
            low_vld_d = 1'b0;
            ptr_d = '0;
            got_d = 1'b0;
        end
    end

    always_comb begin
        buf_we = (accept & odd) | pad_we;
        buf_wa = pad_we ? ptr_q : bus.ioctl_addr[IW:1];
        buf_wd = pad_we ? (low_vld_q ? {8'hFF, low_q} : PAD_WORD) : {bus.ioctl_dout, low_q};
    end

    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n) begin
            dl_q <= 1'b0;
            req_q <= 1'b0;
            wr_q <= 1'b0;
            loaded_q <= 1'b0;
            overrun_q <= 1'b0;
            partial_q <= 1'b0;
            low_vld_q <= 1'b0;
            got_q <= 1'b0;
            low_q <= '0;
            pend_q <= '0;
            ptr_q <= '0;
            addr_q <= '0;
        end else begin
            dl_q <= dl_d;
            req_q <= req_d;
            wr_q <= wr_d;
            loaded_q <= loaded_d;
            overrun_q <= overrun_d;
            partial_q <= partial_d;
            low_vld_q <= low_vld_d;
            got_q <= got_d;
            low_q <= low_d;
            pend_q <= pend_d;
            ptr_q <= ptr_d;
            addr_q <= addr_d;
        end
    end

    bios_word_buf #(.AW(IW)) u_buf (
        .clk_sdr(clk_sdr),
        .reset_n(reset_n),
        .we(buf_we),
        .wa(buf_wa),
        .wd(buf_wd),
        .re(rd_en),
        .ra(addr_q[IW-1:0]),
        .rd(rd_word)
    );

    assign bus.bios_wr = wr_q;
    assign bus.bios_addr = addr_q;
    assign bus.bios_din = rd_word;
    assign bus.bios_loaded = loaded_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_bios_stream_loader.sv
// tb_bios_stream_loader: directed image downloads drained by a modelled system port.
module tb_bios_stream_loader;
    typedef struct {
        int len;
        int seed;
        int bursts;
        int end_addr;
    } vec_t;

    logic clk_sdr = 1'b0;
    logic reset_n = 1'b0;
    int ntests = 0;
    int nfail = 0;
    vec_t vecs[5];

    always #5 clk_sdr = ~clk_sdr;

    bios_stream_loader_if #(.ADDR_W(13)) bus ();

    bios_stream_loader #(.ADDR_W(13), .BURST_LOG2(5), .PAD_WORD(16'hFFFF)) dut (
        .clk_sdr(clk_sdr),
        .reset_n(reset_n),
        .bus(bus)
    );

    function automatic logic [7:0] img_byte(input int len, input int seed, input int i);
        return (i < len) ? 8'((i * 37 + seed * 11 + 1) ^ (i >> 3)) : 8'hFF;
    endfunction

    function automatic logic [15:0] exp_word(input int len, input int seed, input int w);
        return {img_byte(len, seed, 2 * w + 1), img_byte(len, seed, 2 * w)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_sdr);
    endtask

    task automatic load_image(input int len, input int seed);
        tick;
        bus.ioctl_download = 1'b1;
        tick;
        check("start_addr", 32'(bus.bios_addr), 0);
        check("start_loaded", 32'(bus.bios_loaded), 0);
        check("start_wr", 32'(bus.bios_wr), 0);
        check("start_overrun", 32'(bus.overrun), 0);
        for (int i = 0; i < len; i++) begin
            bus.ioctl_wr = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = img_byte(len, seed, i);
            tick;
        end
        bus.ioctl_wr = 1'b0;
        tick;
        bus.ioctl_download = 1'b0;
    endtask

    task automatic wait_wr;
        int n = 0;
        while (bus.bios_wr !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("wr_wait", 32'(bus.bios_wr), 1);
    endtask

    task automatic drain_burst(input int len, input int seed, input int b, input bit last);
        wait_wr;
        check($sformatf("loaded_before_b%0d", b), 32'(bus.bios_loaded), 0);
        bus.bios_req = 1'b1;
        for (int j = 0; j < 32; j++) begin
            tick;
            check($sformatf("din_w%0d", b * 32 + j), 32'(bus.bios_din), 32'(exp_word(len, seed, b * 32 + j)));
            if (j == 31) bus.bios_req = 1'b0;
        end
        tick;
        check($sformatf("wr_gap_b%0d", b), 32'(bus.bios_wr), 0);
        check($sformatf("loaded_after_b%0d", b), 32'(bus.bios_loaded), 32'(last));
    endtask

    task automatic run_image(input vec_t v);
        load_image(v.len, v.seed);
        for (int b = 0; b < v.bursts; b++) drain_burst(v.len, v.seed, b, b == v.bursts - 1);
        check("end_addr", 32'(bus.bios_addr), 32'(v.end_addr));
        check("end_overrun", 32'(bus.overrun), 0);
    endtask

    initial begin
        vecs[0] = '{len: 128, seed: 1, bursts: 2, end_addr: 64};
        vecs[1] = '{len: 70,  seed: 2, bursts: 2, end_addr: 64};
        vecs[2] = '{len: 3,   seed: 3, bursts: 1, end_addr: 32};
        vecs[3] = '{len: 64,  seed: 4, bursts: 1, end_addr: 32};
        vecs[4] = '{len: 65,  seed: 5, bursts: 2, end_addr: 64};
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = '0;
        bus.bios_req = 1'b0;
        #12;
        check("rst_wr", 32'(bus.bios_wr), 0);
        check("rst_addr", 32'(bus.bios_addr), 0);
        check("rst_din", 32'(bus.bios_din), 0);
        check("rst_loaded", 32'(bus.bios_loaded), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        tick;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) run_image(vecs[k]);

        // Stalled system: third half must be dropped and flagged.
        load_image(192, 6);
        check("stall_overrun", 32'(bus.overrun), 1);
        drain_burst(192, 6, 0, 1'b0);
        drain_burst(192, 6, 1, 1'b1);
        repeat (5) tick;
        check("stall_no_third", 32'(bus.bios_wr), 0);
        check("stall_addr", 32'(bus.bios_addr), 64);

        // Byte beyond the image size limit.
        tick;
        bus.ioctl_download = 1'b1;
        tick;
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'h4000;
        bus.ioctl_dout = 8'h5A;
        tick;
        bus.ioctl_wr = 1'b0;
        tick;
        check("range_overrun", 32'(bus.overrun), 1);
        check("range_no_wr", 32'(bus.bios_wr), 0);
        bus.ioctl_download = 1'b0;
        tick;
        tick;
        check("range_loaded", 32'(bus.bios_loaded), 1);

        // Asynchronous reset in the middle of a burst.
        load_image(128, 7);
        wait_wr;
        bus.bios_req = 1'b1;
        repeat (10) tick;
        check("mid_addr", 32'(bus.bios_addr), 10);
        check("mid_din", 32'(bus.bios_din), 32'(exp_word(128, 7, 9)));
        #2 reset_n = 1'b0;
        #1;
        check("arst_wr", 32'(bus.bios_wr), 0);
        check("arst_addr", 32'(bus.bios_addr), 0);
        check("arst_din", 32'(bus.bios_din), 0);
        check("arst_loaded", 32'(bus.bios_loaded), 0);
        check("arst_overrun", 32'(bus.overrun), 0);
        bus.bios_req = 1'b0;
        tick;
        reset_n = 1'b1;
        run_image('{len: 100, seed: 8, bursts: 2, end_addr: 64});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
